// File: rtl/mat_stream_io.sv
// Stream loader/unloader around the matrix-multiply controller.
// Define OUT_RELU_EN to clamp negative result words to zero on output.
module mat_stream_io #(
  parameter int R1   = 2,
  parameter int R2C1 = 14,
  parameter int C2   = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [R1*R2C1*32-1:0]  M1,
  output logic [R2C1*C2*32-1:0]  M2,
  output logic                   mat_start,
  input  logic                   res_done,
  input  logic [R1*C2*32-1:0]    O,
  output logic [31:0]            out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy
);

  localparam int N1   = R1 * R2C1;
  localparam int N2   = R2C1 * C2;
  localparam int NO   = R1 * C2;
  localparam int N12  = (N1 > N2) ? N1 : N2;
  localparam int NMAX = (N12 > NO) ? N12 : NO;
  localparam int IW   = (NMAX > 1) ? $clog2(NMAX) : 1;

  localparam logic [IW-1:0] L1 = IW'(N1 - 1);
  localparam logic [IW-1:0] L2 = IW'(N2 - 1);
  localparam logic [IW-1:0] LO = IW'(NO - 1);

  typedef enum logic [2:0] {
    LOAD_M1,
    LOAD_M2,
    START,
    WAIT,
    DRAIN
  } state_t;

  state_t           state, state_n;
  logic [IW-1:0]    idx, idx_n;
  logic             wr1, wr2, cap;
  logic [NO*32-1:0] o_sh;
  logic [31:0]      raw;

  assign in_ready = (state == LOAD_M1) || (state == LOAD_M2);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    wr1     = 1'b0;
    wr2     = 1'b0;
    cap     = 1'b0;
    unique case (state)
      LOAD_M1: if (in_valid) begin
        wr1 = 1'b1;
        if (idx == L1) begin
          state_n = LOAD_M2;
          idx_n   = '0;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      LOAD_M2: if (in_valid) begin
        wr2 = 1'b1;
        if (idx == L2) begin
          state_n = START;
          idx_n   = '0;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      START: begin
        state_n = WAIT;
        idx_n   = '0;
      end
      WAIT: if (res_done) begin
        cap     = 1'b1;
        state_n = DRAIN;
        idx_n   = '0;
      end
      DRAIN: if (out_ready) begin
        if (idx == LO) begin
          state_n = LOAD_M1;
          idx_n   = '0;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      default: begin
        state_n = LOAD_M1;
        idx_n   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state view so they align with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD_M1;
      idx       <= '0;
      M1        <= '0;
      M2        <= '0;
      o_sh      <= '0;
      mat_start <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (wr1) M1[(N1-1-int'(idx))*32 +: 32] <= in_data;
      if (wr2) M2[(N2-1-int'(idx))*32 +: 32] <= in_data;
      if (cap) o_sh <= O;
      mat_start <= (state_n == START);
      out_valid <= (state_n == DRAIN);
      out_last  <= (state_n == DRAIN) && (idx_n == LO);
      busy      <= !((state_n == LOAD_M1) && (idx_n == '0));
    end
  end

  assign raw = o_sh[(NO-1-int'(idx))*32 +: 32];

`ifdef OUT_RELU_EN
  assign out_data = raw[31] ? 32'd0 : raw;
`else
  assign out_data = raw;
`endif

endmodule
